// File: rtl/wave_trace_render.sv
// Double-buffered scope trace renderer: one bank captures a frame of ADC samples while the
// other is scanned against the VGA pixel counters. Optional vertical linking via TRACE_VLINK_EN.
module wave_trace_render #(
    parameter int          H_ACTIVE    = 640,
    parameter int          WAVE_ROWS   = 384,
    parameter logic [7:0]  TRACE_LEVEL = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic       trace_on,
    output logic [7:0] trace_green,
    output logic       frame_swapped
);

    localparam int              AW        = $clog2(2 * H_ACTIVE);
    localparam logic [AW-1:0]   BANK_OFS  = AW'(H_ACTIVE);
    localparam logic [9:0]      X_END     = 10'(H_ACTIVE);
    localparam logic [9:0]      Y_END     = 10'(WAVE_ROWS);
    localparam logic [9:0]      Y_BOT     = 10'(WAVE_ROWS - 1);
    localparam logic [9:0]      WPTR_LAST = 10'(H_ACTIVE - 1);

    // sel_q names the write bank; the display bank is the other one.
    logic            sel_q;
    logic [9:0]      wptr_q;
    logic            disp_filled_q;
    logic            frame_swapped_q;

    logic            bank_full [2];
    logic [9:0]      bank_cnt  [2];

    logic            wr_full;
    logic [9:0]      disp_cnt;
    logic            wr_accept;
    logic            wr_done;
    logic            swap_pt;
    logic            do_swap;

    assign wr_full   = sel_q ? bank_full[1] : bank_full[0];
    assign disp_cnt  = sel_q ? bank_cnt[0]  : bank_cnt[1];
    assign wr_ready  = !rst && !wr_full;
    assign wr_accept = wr_valid && wr_ready;
    assign wr_done   = wr_accept && (wr_last || (wptr_q == WPTR_LAST));
    assign swap_pt   = (xCount == 10'd0) && (yCount == Y_END);
    assign do_swap   = swap_pt && wr_full;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = 1'(gi);
            logic       full_q;
            logic [9:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    full_q <= 1'b0;
                    cnt_q  <= 10'd0;
                end else if (do_swap && (sel_q != BANK_ID)) begin
                    // outgoing display bank is recycled as the next write bank
                    full_q <= 1'b0;
                    cnt_q  <= 10'd0;
                end else if (wr_done && (sel_q == BANK_ID)) begin
                    full_q <= 1'b1;
                    cnt_q  <= wptr_q + 10'd1;
                end
            end

            assign bank_full[gi] = full_q;
            assign bank_cnt[gi]  = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q           <= 1'b0;
            wptr_q          <= 10'd0;
            disp_filled_q   <= 1'b0;
            frame_swapped_q <= 1'b0;
        end else begin
            frame_swapped_q <= do_swap;
            if (do_swap) begin
                sel_q         <= ~sel_q;
                wptr_q        <= 10'd0;
                disp_filled_q <= 1'b1;
            end else if (wr_accept) begin
                wptr_q <= wptr_q + 10'd1;
            end
        end
    end

    // Both banks share one RAM; bank 1 sits H_ACTIVE words above bank 0.
    logic [7:0]    mem [2 * H_ACTIVE];
    logic [7:0]    rd_q;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [9:0]    rd_x;

    assign wr_addr = (sel_q ? BANK_OFS : '0) + AW'(wptr_q);
    assign rd_x    = (xCount < X_END) ? xCount : 10'd0;
    assign rd_addr = (sel_q ? '0 : BANK_OFS) + AW'(rd_x);

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[rd_addr];
    end

    logic [9:0] x1_q;
    logic [9:0] y1_q;
    logic [9:0] s3_d;
    logic [9:0] ypix_d;
    logic       inreg_d;
    logic       valid_d;
    logic       hit_d;
    logic       trace_on_q;
    logic [7:0] trace_green_q;

    assign s3_d    = {2'b00, rd_q} * 10'd3;
    assign ypix_d  = Y_BOT - (s3_d >> 1);
    assign inreg_d = (x1_q < X_END) && (y1_q < Y_END);
    assign valid_d = disp_filled_q && (x1_q < disp_cnt);

`ifdef TRACE_VLINK_EN
    logic [9:0] yprev_q;
    logic [9:0] ya_d;
    logic [9:0] lo_d;
    logic [9:0] hi_d;

    // column 0 has no left neighbour, so it links only to itself
    assign ya_d  = (x1_q == 10'd0) ? ypix_d : yprev_q;
    assign lo_d  = (ya_d < ypix_d) ? ya_d : ypix_d;
    assign hi_d  = (ya_d < ypix_d) ? ypix_d : ya_d;
    assign hit_d = (y1_q >= lo_d) && (y1_q <= hi_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            yprev_q <= 10'd0;
        end else begin
            yprev_q <= ypix_d;
        end
    end
`else
    assign hit_d = (y1_q == ypix_d);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q          <= 10'd0;
            y1_q          <= 10'd0;
            trace_on_q    <= 1'b0;
            trace_green_q <= 8'd0;
        end else begin
            x1_q <= xCount;
            y1_q <= yCount;
            if (inreg_d && valid_d && hit_d) begin
                trace_on_q    <= 1'b1;
                trace_green_q <= TRACE_LEVEL;
            end else begin
                trace_on_q    <= 1'b0;
                trace_green_q <= 8'd0;
            end
        end
    end

    assign trace_on      = trace_on_q;
    assign trace_green   = trace_green_q;
    assign frame_swapped = frame_swapped_q;

endmodule

// File: tb/tb_wave_trace_render.sv
// Directed bench for wave_trace_render: compressed pixel scans of selected rows, with the
// producer stream and swap points driven from one process.
module tb_wave_trace_render;

    localparam int H    = 640;
    localparam int ROWS = 384;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_last;
    logic       wr_ready;
    logic [9:0] xCount;
    logic [9:0] yCount;
    logic       trace_on;
    logic [7:0] trace_green;
    logic       frame_swapped;

    always #5 clk = ~clk;

    wave_trace_render #(
        .H_ACTIVE   (H),
        .WAVE_ROWS  (ROWS),
        .TRACE_LEVEL(8'd255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .xCount       (xCount),
        .yCount       (yCount),
        .trace_on     (trace_on),
        .trace_green  (trace_green),
        .frame_swapped(frame_swapped)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int prod_en    = 0;
    int prod_mode  = 0;
    int prod_idx   = 0;
    int prod_limit = 0;
    int prod_len   = 640;
    int swap_pulses = 0;

    logic       obs_on;
    logic [7:0] obs_green;

    logic [7:0] disp_data [H];
    int         disp_cnt    = 0;
    bit         disp_filled = 0;

    function automatic logic [7:0] pat(input int mode, input int k);
        if (mode == 0) return 8'd128;
        if (mode == 1) return (k % 2 == 0) ? 8'd0 : 8'd255;
        case (k % 3)
            0:       return 8'd0;
            1:       return 8'd128;
            default: return 8'd255;
        endcase
    endfunction

    function automatic int ypix(input logic [7:0] s);
        return 383 - ((int'(s) * 3) >> 1);
    endfunction

    function automatic bit exp_lit(input int x, input int y);
        int yp;
        int yq;
        if (!disp_filled || x >= disp_cnt || y >= ROWS) return 1'b0;
        yp = ypix(disp_data[x]);
`ifdef TRACE_VLINK_EN
        yq = (x == 0) ? yp : ypix(disp_data[x-1]);
        if (yq < yp) return (y >= yq) && (y <= yp);
        return (y >= yp) && (y <= yq);
`else
        yq = yp;
        return y == yq;
`endif
    endfunction

    task automatic load_model(input int mode, input int base, input int cnt);
        for (int i = 0; i < H; i++) disp_data[i] = (i < cnt) ? pat(mode, base + i) : 8'd0;
        disp_cnt    = cnt;
        disp_filled = 1'b1;
    endtask

    // One pixel clock: sample outputs, then present the next pixel and producer beat.
    task automatic step(input int x, input int y);
        @(negedge clk);
        obs_on    = trace_on;
        obs_green = trace_green;
        if (frame_swapped === 1'b1) swap_pulses++;
        xCount = x[9:0];
        yCount = y[9:0];
        if (prod_en != 0 && prod_idx < prod_limit) begin
            wr_valid = 1'b1;
            wr_data  = pat(prod_mode, prod_idx);
            wr_last  = (prod_idx % prod_len) == (prod_len - 1);
        end else begin
            wr_valid = 1'b0;
            wr_data  = 8'd0;
            wr_last  = 1'b0;
        end
        if (wr_valid && wr_ready === 1'b1) prod_idx++;
    endtask

    task automatic scan_row(input int y, input string tag);
        logic [H-1:0] ov;
        logic [H-1:0] gv;
        logic [H-1:0] ev;
        bit           gbad;
        int           fx;
        gbad = 1'b0;
        for (int i = 0; i < H + 2; i++) begin
            step((i < H) ? i : H, y);
            if (i >= 2) begin
                ov[i-2] = obs_on;
                gv[i-2] = (obs_green !== 8'd0);
                if (obs_green !== 8'd0 && obs_green !== 8'd255) gbad = 1'b1;
                ev[i-2] = exp_lit(i - 2, y);
            end
        end
        n_cmp++;
        if (ov !== ev) begin
            n_bad++;
            fx = 0;
            for (int i = 0; i < H; i++) if (ov[i] !== ev[i]) begin fx = i; break; end
            $display("FAIL %s row %0d trace_on: first x=%0d actual %0b required %0b",
                     tag, y, fx, ov[fx], ev[fx]);
        end
        n_cmp++;
        if (gv !== ev || gbad) begin
            n_bad++;
            fx = 0;
            for (int i = 0; i < H; i++) if (gv[i] !== ev[i]) begin fx = i; break; end
            $display("FAIL %s row %0d trace_green: first x=%0d lit actual %0b required %0b (bad level %0b)",
                     tag, y, fx, gv[fx], ev[fx], gbad);
        end
        $display("row %s y=%0d checked", tag, y);
    endtask

    task automatic swap_point(input int expect_n, input string tag);
        int p0;
        p0 = swap_pulses;
        step(0, ROWS);
        step(H, 500);
        n_cmp++;
        if (swap_pulses - p0 != expect_n) begin
            n_bad++;
            $display("FAIL %s frame_swapped pulses: actual %0d required %0d", tag, swap_pulses - p0, expect_n);
        end
        $display("swap %s pulses=%0d", tag, swap_pulses - p0);
    endtask

    task automatic wait_ready_low(input string tag);
        int c;
        c = 0;
        while (wr_ready === 1'b1 && c < 3000) begin
            step(H, 500);
            c++;
        end
        n_cmp++;
        if (wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s fill timeout: wr_ready actual %b required 0", tag, wr_ready);
        end
    endtask

    task automatic check_int(input int act, input int req, input string tag);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", tag, act, req);
        end
        $display("check %s value=%0d", tag, act);
    endtask

    task automatic start_prod(input int mode, input int limit, input int len);
        prod_mode  = mode;
        prod_idx   = 0;
        prod_limit = limit;
        prod_len   = len;
        prod_en    = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = 8'd0;
        xCount = 10'd640; yCount = 10'd500;
        repeat (3) @(negedge clk);
        #1;
        check_int(int'(wr_ready), 0, "reset wr_ready");
        check_int(int'(trace_on), 0, "reset trace_on");
        check_int(int'(trace_green), 0, "reset trace_green");
        check_int(int'(frame_swapped), 0, "reset frame_swapped");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_int(int'(wr_ready), 1, "post-reset wr_ready");
    endtask

    task automatic test_flat();
        start_prod(0, 640, 640);
        wait_ready_low("flat");
        check_int(prod_idx, 640, "flat accepted");
        scan_row(191, "flat pre-swap");
        swap_point(1, "flat");
        load_model(0, 0, 640);
        scan_row(191, "flat");
        scan_row(190, "flat");
        scan_row(192, "flat");
    endtask

    task automatic test_alternate();
        start_prod(1, 640, 640);
        wait_ready_low("alt");
        swap_point(1, "alt");
        load_model(1, 0, 640);
        scan_row(383, "alt");
        scan_row(1, "alt");
        scan_row(200, "alt");
    endtask

    task automatic test_short_frame();
        start_prod(0, 100, 100);
        wait_ready_low("short");
        check_int(prod_idx, 100, "short accepted");
        swap_point(1, "short");
        load_model(0, 0, 100);
        scan_row(191, "short");
        scan_row(383, "short");
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = swap_pulses;
        start_prod(2, 1 << 30, 640);
        wait_ready_low("b2b");
        check_int(prod_idx, 640, "b2b frame0 accepted");
        swap_point(1, "b2b first");
        load_model(2, 0, 640);
        scan_row(383, "b2b f0");
        scan_row(191, "b2b f0");
        scan_row(1, "b2b f0");
        check_int(prod_idx, 1280, "b2b frame1 accepted");
        swap_point(1, "b2b second");
        load_model(2, 640, 640);
        scan_row(383, "b2b f1");
        scan_row(191, "b2b f1");
        scan_row(1, "b2b f1");
        check_int(prod_idx, 1920, "b2b frame2 accepted");
        prod_en = 0;
        swap_point(1, "b2b third");
        load_model(2, 1280, 640);
        check_int(swap_pulses - p0, 3, "b2b total pulses");
    endtask

    task automatic test_partial();
        int c;
        start_prod(0, 300, 1 << 30);
        c = 0;
        while (prod_idx < 300 && c < 2000) begin
            step(H, 500);
            c++;
        end
        check_int(prod_idx, 300, "partial accepted");
        check_int(int'(wr_ready), 1, "partial wr_ready");
        swap_point(0, "partial");
        scan_row(191, "partial old frame");
        scan_row(1, "partial old frame");
    endtask

    task automatic test_reset_midfill();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_int(int'(wr_ready), 0, "midfill reset wr_ready");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_int(int'(wr_ready), 1, "midfill post-reset wr_ready");
        disp_filled = 1'b0;
        prod_en = 0;
        scan_row(191, "after reset");
        swap_point(0, "after reset");
        start_prod(0, 640, 640);
        wait_ready_low("refill");
        check_int(prod_idx, 640, "refill accepted");
        swap_point(1, "refill");
        load_model(0, 0, 640);
        scan_row(191, "refill");
        scan_row(190, "refill");
    endtask

    initial begin
        test_reset();
        test_flat();
        test_alternate();
        test_short_frame();
        test_back_to_back();
        test_partial();
        test_reset_midfill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
